// File: rtl/up_down_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// up_down_sweep_ctrl_if
//
// Purpose
//   Bundles the configuration/handshake side and the counter side of the
//   up/down sweep sequencer into one interface, so the sequencer, the
//   config logic and the counter share a single set of wires.
//
// Signals
//   start       request a run (sampled only while the sequencer is idle)
//   abort       terminate an active run
//   lo_bound    lower turn point        (W bits)
//   hi_bound    upper turn point        (W bits)
//   num_sweeps  number of LO->HI->LO sweeps (SW bits)
//   cnt_value   current counter output  (W bits)
//   cnt_clr     counter clear request
//   cnt_en      counter step enable
//   cnt_mode    1 = count up, 0 = count down
//   busy        sequencer is running
//   done        one-cycle pulse, run completed normally
//   err         one-cycle pulse, start rejected because of a bad config
//   sweep_idx   0-based index of the current sweep (SW bits)
//
// Modports
//   master  the surrounding system: drives start/abort/config and cnt_value
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface up_down_sweep_ctrl_if #(
    parameter int W  = 4,
    parameter int SW = 8
);

    logic          start;
    logic          abort;
    logic [W-1:0]  lo_bound;
    logic [W-1:0]  hi_bound;
    logic [SW-1:0] num_sweeps;
    logic [W-1:0]  cnt_value;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_mode;
    logic          busy;
    logic          done;
    logic          err;
    logic [SW-1:0] sweep_idx;

    modport master (
        output start,
        output abort,
        output lo_bound,
        output hi_bound,
        output num_sweeps,
        output cnt_value,
        input  cnt_clr,
        input  cnt_en,
        input  cnt_mode,
        input  busy,
        input  done,
        input  err,
        input  sweep_idx
    );

    modport slave (
        input  start,
        input  abort,
        input  lo_bound,
        input  hi_bound,
        input  num_sweeps,
        input  cnt_value,
        output cnt_clr,
        output cnt_en,
        output cnt_mode,
        output busy,
        output done,
        output err,
        output sweep_idx
    );

endinterface

// File: rtl/up_down_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// up_down_sweep_ctrl
//
// Purpose
//   Sequencer for a W-bit up/down counter (clr/en/mode in, count out).
//   On an accepted start it clears the counter, ramps it up to LO, then
//   runs NUM triangle sweeps LO->HI->LO and finishes with a one-cycle done
//   pulse. A start with a bad configuration (lo >= hi or num == 0) is
//   rejected with a one-cycle err pulse.
//
// Parameters
//   W   counter width; width of the bounds and of cnt_value
//   SW  width of the sweep count and of the sweep index
//
// Ports
//   clk    in  rising-edge clock
//   reset  in  synchronous active-low reset (0 = reset)
//   bus    slave side of up_down_sweep_ctrl_if:
//            in : start, abort, lo_bound, hi_bound, num_sweeps, cnt_value
//            out: cnt_clr, cnt_en, cnt_mode, busy, done, err, sweep_idx
//
// Notes
//   cnt_en/cnt_mode/cnt_clr are decoded combinationally from the state and
//   the live counter value, so the counter stops exactly on a bound without
//   overshoot. Each turn point therefore spends one dwell cycle with en=0.
//   Reset does not touch the counter itself.
// -----------------------------------------------------------------------------
module up_down_sweep_ctrl #(
    parameter int W  = 4,
    parameter int SW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    up_down_sweep_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        PRIME  = 3'd2,
        UP     = 3'd3,
        DOWN   = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t        state;
    logic [W-1:0]  lo_q;
    logic [W-1:0]  hi_q;
    logic [SW-1:0] num_q;
    logic [SW-1:0] sweep_idx_q;
    logic          done_q;
    logic          err_q;

    logic          cfg_ok;
    logic          last_sweep;
    logic          aborting;
    logic          clr_c;
    logic          en_c;
    logic          mode_c;

    // A start is only accepted with a non-empty range and at least one sweep.
    assign cfg_ok     = (bus.lo_bound < bus.hi_bound) && (bus.num_sweeps != '0);
    assign last_sweep = (sweep_idx_q == (num_q - SW'(1)));
    assign aborting   = bus.abort && (state != IDLE);

    // Main sequencer: state, captured configuration, sweep index and the
    // registered done/err pulses. Abort wins over every normal transition
    // of an active run; done/err default low so they are single-cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            num_q       <= '0;
            sweep_idx_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (aborting) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (cfg_ok) begin
                                lo_q        <= bus.lo_bound;
                                hi_q        <= bus.hi_bound;
                                num_q       <= bus.num_sweeps;
                                sweep_idx_q <= '0;
                                state       <= CLEAR;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        state <= PRIME;
                    end
                    PRIME: begin
                        if (bus.cnt_value >= lo_q) begin
                            state <= UP;
                        end
                    end
                    UP: begin
                        if (bus.cnt_value >= hi_q) begin
                            state <= DOWN;
                        end
                    end
                    DOWN: begin
                        if (bus.cnt_value <= lo_q) begin
                            if (last_sweep) begin
                                state  <= FINISH;
                                done_q <= 1'b1;
                            end else begin
                                sweep_idx_q <= sweep_idx_q + SW'(1);
                                state       <= UP;
                            end
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Counter control decode. The enable looks at the live counter value so
    // the step that would pass a bound is never issued; an abort kills both
    // clear and enable in the very cycle it is seen.
    always_comb begin
        clr_c  = 1'b0;
        en_c   = 1'b0;
        mode_c = 1'b1;
        case (state)
            CLEAR: begin
                clr_c = 1'b1;
            end
            PRIME: begin
                en_c = (bus.cnt_value < lo_q);
            end
            UP: begin
                en_c = (bus.cnt_value < hi_q);
            end
            DOWN: begin
                mode_c = 1'b0;
                en_c   = (bus.cnt_value > lo_q);
            end
            default: begin
                en_c = 1'b0;
            end
        endcase
        if (aborting) begin
            clr_c = 1'b0;
            en_c  = 1'b0;
        end
    end

    assign bus.cnt_clr   = clr_c;
    assign bus.cnt_en    = en_c;
    assign bus.cnt_mode  = mode_c;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.sweep_idx = sweep_idx_q;

endmodule
